// File: rtl/video_window_reader_if.sv
// Read-port bundle of video_window_reader: raster position, window setup,
// RAM read strobe/address/data and the aligned output pixel.
interface video_window_reader_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [11:0]       hcnt;
  logic [11:0]       vcnt;
  logic [11:0]       xstart;
  logic [11:0]       ystart;
  logic [1:0]        scale;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [23:0]       rd_data;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              active;
  logic              frame_start;

  modport master (
    input  hcnt, vcnt, xstart, ystart, scale, rd_data,
    output rd_en, rd_addr, r, g, b, active, frame_start
  );

  modport slave (
    output hcnt, vcnt, xstart, ystart, scale, rd_data,
    input  rd_en, rd_addr, r, g, b, active, frame_start
  );
endinterface

// File: rtl/video_window_reader.sv
// Frame-buffer window reader: WIN_W x WIN_H window placed in the raster, read
// addresses from hcnt/vcnt, pixel realignment for RAM_LAT. REPLICATE_EN enables 1x/2x/4x.
module video_window_reader #(
  parameter int unsigned ADDR_W  = 18,
  parameter int unsigned WIN_W   = 320,
  parameter int unsigned WIN_H   = 240,
  parameter int unsigned HTOTAL  = 1650,
  parameter int unsigned VTOTAL  = 750,
  parameter int unsigned RAM_LAT = 1,
  parameter logic [23:0] BORDER  = 24'hFFFFFF
) (
  input logic            i_clk_74M,
  input logic            i_rst,
  video_window_reader_if.master bus
);

  if (RAM_LAT < 1 || RAM_LAT > 4) begin : g_bad_lat
    $error("RAM_LAT must be 1..4");
  end
  if (64'(WIN_W) * 64'(WIN_H) > (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("WIN_W*WIN_H-1 does not fit ADDR_W");
  end

  localparam logic [11:0]       H_LAST   = 12'(HTOTAL - 1);
  localparam logic [11:0]       V_LAST   = 12'(VTOTAL - 1);
  localparam logic [ADDR_W-1:0] W_STEP   = ADDR_W'(WIN_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIN_W - 1);
  localparam int unsigned       LN_W     = $clog2(WIN_H * 4 + 1);

  typedef enum logic [1:0] {V_IDLE, V_ACTIVE, V_DONE} vstate_t;

  vstate_t           state_q, state_d;
  logic [11:0]       xstart_q, ystart_q;
  logic [ADDR_W-1:0] line_base_q, col_q, rd_addr_q;
  logic [LN_W-1:0]   lines_q, lines_last;
  logic              spanning_q, rd_en_q, frame_start_q;
  logic [RAM_LAT:0]  dly_q;
  logic [23:0]       pix_q;
  logic              frame_edge, line_end, enter, line_ok, span_now, span_last;
  logic              h_step, v_step;

`ifdef REPLICATE_EN
  logic [1:0] scale_q, rep_max, hrep_q, vrep_q;

  always_comb begin
    rep_max    = 2'd0;
    lines_last = LN_W'(WIN_H - 1);
    case (scale_q)
      2'd1: begin rep_max = 2'd1; lines_last = LN_W'(2 * WIN_H - 1); end
      2'd2: begin rep_max = 2'd3; lines_last = LN_W'(4 * WIN_H - 1); end
      default: ;
    endcase
    h_step = (hrep_q == rep_max);
    v_step = (vrep_q == rep_max);
  end
`else
  always_comb begin
    lines_last = LN_W'(WIN_H - 1);
    h_step     = 1'b1;
    v_step     = 1'b1;
  end
`endif

  always_comb begin
    frame_edge = (bus.hcnt == H_LAST) && (bus.vcnt == V_LAST);
    line_end   = (bus.hcnt == H_LAST);
    enter      = (state_q == V_IDLE) && (bus.hcnt == 12'd0) && (bus.vcnt == ystart_q);
    // The entry cycle must already count as active so a span at column 0 opens on time
    line_ok    = (state_q == V_ACTIVE) || enter;
    span_now   = line_ok && (spanning_q || (bus.hcnt == xstart_q));
    span_last  = ((col_q == COL_LAST) && h_step) || line_end;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      V_IDLE:   if (enter) state_d = V_ACTIVE;
      V_ACTIVE: if (line_end && ((lines_q == lines_last) || (bus.vcnt == V_LAST))) state_d = V_DONE;
      V_DONE:   state_d = V_DONE;
      default:  state_d = V_IDLE;
    endcase
    if (frame_edge) state_d = V_IDLE;
  end

  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      state_q       <= V_IDLE;
      xstart_q      <= '0;
      ystart_q      <= '0;
      line_base_q   <= '0;
      col_q         <= '0;
      lines_q       <= '0;
      spanning_q    <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      frame_start_q <= 1'b0;
      dly_q         <= '0;
      pix_q         <= BORDER;
`ifdef REPLICATE_EN
      scale_q       <= '0;
      hrep_q        <= '0;
      vrep_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rd_en_q       <= span_now;
      rd_addr_q     <= line_base_q + col_q;
      frame_start_q <= frame_edge;

      if (frame_edge || enter) lines_q <= '0;
      else if ((state_q == V_ACTIVE) && line_end) lines_q <= lines_q + LN_W'(1);

      // Boundary clearing overrides any span-end or column step in the same cycle
      if (frame_edge) begin
        xstart_q    <= bus.xstart;
        ystart_q    <= bus.ystart;
        line_base_q <= '0;
        col_q       <= '0;
        spanning_q  <= 1'b0;
`ifdef REPLICATE_EN
        scale_q     <= bus.scale;
        hrep_q      <= '0;
        vrep_q      <= '0;
`endif
      end else if (span_now) begin
        if (span_last) begin
          spanning_q <= 1'b0;
          col_q      <= '0;
          if (v_step) line_base_q <= line_base_q + W_STEP;
`ifdef REPLICATE_EN
          hrep_q     <= '0;
          vrep_q     <= v_step ? 2'd0 : vrep_q + 2'd1;
`endif
        end else begin
          spanning_q <= 1'b1;
          if (h_step) col_q <= col_q + ADDR_W'(1);
`ifdef REPLICATE_EN
          hrep_q     <= h_step ? 2'd0 : hrep_q + 2'd1;
`endif
        end
      end

      // dly_q[RAM_LAT-1] lines up with the returned RAM word; dly_q[RAM_LAT] with pix_q
      dly_q <= {dly_q[RAM_LAT-1:0], rd_en_q};
      pix_q <= dly_q[RAM_LAT-1] ? bus.rd_data : BORDER;
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.frame_start = frame_start_q;
  assign bus.active      = dly_q[RAM_LAT];
  assign bus.r           = pix_q[23:16];
  assign bus.g           = pix_q[15:8];
  assign bus.b           = pix_q[7:0];

endmodule

// File: tb/tb_video_window_reader.sv
// Scoreboard bench for video_window_reader on a small raster; honours REPLICATE_EN.
module tb_video_window_reader;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned WIN_W   = 8;
  localparam int unsigned WIN_H   = 4;
  localparam int unsigned HTOTAL  = 24;
  localparam int unsigned VTOTAL  = 12;
  localparam int unsigned RAM_LAT = 2;
  localparam logic [23:0] BORDER  = 24'hFFFFFF;
  localparam int unsigned PIPE    = 2 + RAM_LAT;
  localparam int unsigned FRAME   = HTOTAL * VTOTAL;
`ifdef REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct packed {
    logic        active;
    logic [23:0] pix;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_window_reader_if #(.ADDR_W(ADDR_W)) bus();

  video_window_reader #(
    .ADDR_W(ADDR_W), .WIN_W(WIN_W), .WIN_H(WIN_H), .HTOTAL(HTOTAL),
    .VTOTAL(VTOTAL), .RAM_LAT(RAM_LAT), .BORDER(BORDER)
  ) dut (
    .i_clk_74M(clk),
    .i_rst(rst),
    .bus(bus)
  );

  function automatic logic [23:0] ram_word(logic [ADDR_W-1:0] a);
    return {8'hC3, a[7:0], ~a[7:0]};
  endfunction

  logic [23:0] ram_q [RAM_LAT];
  always_ff @(posedge clk) begin
    ram_q[0] <= bus.rd_en ? ram_word(bus.rd_addr) : 24'h0BAD00;
    for (int unsigned k = 1; k < RAM_LAT; k++) ram_q[k] <= ram_q[k-1];
  end
  assign bus.rd_data = ram_q[RAM_LAT-1];

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  exp_t        sb[$];

  int unsigned h = 0, v = 0;
  int unsigned xs_in = 0, ys_in = 0, sc_in = 0;
  int unsigned m_xs = 0, m_ys = 0, m_s = 1;
  bit          armed = 1'b0;
  bit          prev_en = 1'b0, prev_fs = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (h=%0d v=%0d t=%0t)", tag, got, exp, h, v, $time);
    end
  endtask

  task automatic model(input int unsigned hh, input int unsigned vv,
                       output bit en, output int unsigned addr);
    en = 1'b0;
    addr = 0;
    if (armed && m_ys < VTOTAL && vv >= m_ys && (vv - m_ys) < WIN_H * m_s &&
        m_xs < HTOTAL && hh >= m_xs && (hh - m_xs) < WIN_W * m_s) begin
      en = 1'b1;
      addr = ((vv - m_ys) / m_s) * WIN_W + (hh - m_xs) / m_s;
    end
  endtask

  task automatic step(input bit do_rst);
    exp_t        e;
    bit          en;
    bit          boundary;
    int unsigned a;
    @(negedge clk);
    if (sb.size() >= PIPE) begin
      e = sb.pop_front();
      check("active", 32'(bus.active), 32'(e.active));
      check("pixel", 32'({bus.r, bus.g, bus.b}), 32'(e.pix));
    end
    check("rd_en", 32'(bus.rd_en), 32'(prev_en));
    if (prev_en) check("rd_addr", 32'(bus.rd_addr), 32'(prev_addr));
    check("frame_start", 32'(bus.frame_start), 32'(prev_fs));

    if (do_rst) foreach (sb[i]) sb[i] = '{1'b0, BORDER};
    model(h, v, en, a);
    if (do_rst) en = 1'b0;
    boundary = (h == HTOTAL - 1) && (v == VTOTAL - 1);
    rst        = do_rst;
    bus.hcnt   = 12'(h);
    bus.vcnt   = 12'(v);
    bus.xstart = 12'(xs_in);
    bus.ystart = 12'(ys_in);
    bus.scale  = 2'(sc_in);
    sb.push_back(en ? exp_t'{1'b1, ram_word(ADDR_W'(a))} : exp_t'{1'b0, BORDER});
    prev_en   = en;
    prev_addr = ADDR_W'(a);
    prev_fs   = !do_rst && boundary;
    if (do_rst) armed = 1'b0;
    else if (boundary) begin
      m_xs  = xs_in;
      m_ys  = ys_in;
      m_s   = !REP ? 1 : (sc_in == 1) ? 2 : (sc_in == 2) ? 4 : 1;
      armed = 1'b1;
    end
    if (h == HTOTAL - 1) begin
      h = 0;
      v = (v == VTOTAL - 1) ? 0 : v + 1;
    end else h = h + 1;
  endtask

  task automatic run(input int unsigned cycles);
    repeat (cycles) step(1'b0);
  endtask

  int unsigned scen [9][3] = '{
    '{3, 2, 0}, '{0, 0, 1}, '{20, 3, 0}, '{5, 1, 2}, '{0, 10, 0},
    '{30, 0, 0}, '{2, 20, 0}, '{16, 0, 3}, '{7, 4, 1}
  };

  initial begin
    bus.hcnt = '0; bus.vcnt = '0; bus.xstart = '0; bus.ystart = '0; bus.scale = '0;
    repeat (5) step(1'b1);
    for (int unsigned s = 0; s < 9; s++) begin
      xs_in = scen[s][0];
      ys_in = scen[s][1];
      sc_in = scen[s][2];
      run(2 * FRAME);
    end

    // Mid-frame change of xstart: current frame keeps the old value
    xs_in = 0; ys_in = 0; sc_in = 0;
    run(FRAME);
    run(HTOTAL * 5);
    xs_in = 12;
    run(2 * FRAME);

    // Reset inside the window, then resume on the following frame
    xs_in = 3; ys_in = 2; sc_in = 0;
    while (!(v == 3 && h == 6)) step(1'b0);
    step(1'b1);
    step(1'b1);
    run(2 * FRAME);

    for (int unsigned k = 0; k < 6; k++) begin
      run($urandom_range(FRAME - 1, 1));
      xs_in = $urandom_range(HTOTAL + 2, 0);
      ys_in = $urandom_range(VTOTAL + 1, 0);
      sc_in = $urandom_range(3, 0);
      run(FRAME);
    end
    run(PIPE + 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/video_window_reader.md
# video_window_reader

Parametrised pixel-clock read controller for a frame buffer. It places a WIN_W x WIN_H window anywhere in the raster, with optional integer pixel replication (1x/2x/4x). It generates dual-port-RAM read strobes and addresses from the timing generator's hcnt/vcnt, and aligns the returned pixels to the raster for any RAM read latency. Outside the window it drives a border colour. It sits on the read port of the GMII-fed frame buffer, ahead of the HDMI encoder.

## Interface
- ADDR_W, 18, frame-buffer address width
- WIN_W, 320, source image width in pixels
- WIN_H, 240, source image height in lines
- HTOTAL, 1650, pixels per raster line (hcnt wraps HTOTAL-1 -> 0)
- VTOTAL, 750, lines per raster frame (vcnt wraps VTOTAL-1 -> 0)
- RAM_LAT, 1, RAM read latency in cycles, from o_rd_en to valid i_rd_data (1..4)
- BORDER, 24'hFFFFFF, {R,G,B} driven outside the window
- i_clk_74M in 1 pixel clock
- i_rst in 1 synchronous, active-high reset
- i_hcnt in 12 horizontal counter from the timing generator
- i_vcnt in 12 vertical counter from the timing generator
- i_xstart in 12 window left column (raster coordinates)
- i_ystart in 12 window top line
- i_scale in 2 replication: 0=1x, 1=2x, 2=4x, 3=1x
- o_rd_en out 1 RAM read enable
- o_rd_addr out ADDR_W RAM read address (row-major, WIN_W per row)
- i_rd_data in 24 RAM data {R[23:16],G[15:8],B[7:0]}
- o_r, o_g, o_b out 8 each output pixel
- o_active out 1 high when the output pixel comes from the window
- o_frame_start out 1 one-cycle pulse at frame boundary

## Operation
- Frame boundary: the cycle with i_hcnt==HTOTAL-1 and i_vcnt==VTOTAL-1.
  - Latches i_xstart, i_ystart and i_scale into shadow registers (S = 1, 2 or 4).
  - Clears the line base, column and replication counters.
  - Pulses o_frame_start.
  - Changing the inputs mid-frame has no effect until the next boundary.
- Vertical state: IDLE -> ACTIVE -> DONE -> IDLE.
  - IDLE -> ACTIVE at the line start (i_hcnt==0) where i_vcnt==ystart.
  - ACTIVE counts lines; it leaves to DONE after WIN_H*S lines, or when i_vcnt==VTOTAL-1, whichever comes first.
  - DONE holds until the frame boundary, then returns to IDLE.
  - If ystart >= VTOTAL, the block never leaves IDLE.
- Horizontal span, within ACTIVE lines:
  - Opens when i_hcnt==xstart.
  - Closes after WIN_W*S pixels, or after the pixel with i_hcnt==HTOTAL-1; the window is clipped and there is no wrap into the next line.
  - If xstart >= HTOTAL, nothing is read.
- Addressing:
  - o_rd_addr = line_base + col.
  - col increments once every S span pixels, via the horizontal replication counter.
  - At each span end, col resets to 0. The vertical replication counter increments; when it reaches S-1 it resets and line_base += WIN_W, otherwise line_base is unchanged (the same source row is re-read).
  - All arithmetic is ADDR_W wide and unsigned.
  - The maximum address is WIN_W*WIN_H-1; it must fit ADDR_W (elaboration check).
- o_rd_en is high exactly on the span pixels. A clipped span issues fewer reads, but line_base still advances normally.
- Output:
  - A delay line of 1+RAM_LAT stages carries the span flag.
  - When the delayed flag is high, o_r/o_g/o_b come from i_rd_data; otherwise they come from BORDER.
  - o_active is the delayed flag.

## Timing
- Reset values: o_rd_en=0, o_rd_addr=0, o_active=0, o_frame_start=0, o_r/o_g/o_b=BORDER; all counters 0; vertical state IDLE; shadows xstart=0, ystart=0, S=1.
  - Reset mid-frame takes effect at the next edge.
  - Output resumes at the first frame boundary after reset is released.
- o_rd_en and o_rd_addr are registered: valid 1 cycle after the i_hcnt value they belong to.
- Pixel latency: the pixel for raster position (h,v) appears on o_r/o_g/o_b exactly 2+RAM_LAT cycles after i_hcnt==h. The timing generator delays its syncs to match.
- o_frame_start is asserted 1 cycle after the boundary cycle.
- Simultaneous events:
  - Frame boundary together with span end: boundary clearing wins.
  - Span end together with a col increment: col resets.

## Configuration
- REPLICATE_EN defined: i_scale is honoured as above.
- REPLICATE_EN undefined: i_scale is ignored, S is fixed at 1, and the replication counters are removed. All other behaviour and latency are unchanged.

## Test plan
- Reset mid-window with xstart=100, ystart=50 -> next cycle o_rd_en=0 and o_r/o_g/o_b=FF/FF/FF; the first read after release is addr 0 at i_vcnt=50, i_hcnt=100 of the following frame.
- 1x, xstart=100, ystart=50, RAM_LAT=1, RAM returns addr[23:0] -> o_active rises 3 cycles after i_hcnt=100 on i_vcnt=50; row 0 addrs run 0..319; the first read of line 51 is addr 320; the last read of the frame is 76799 at i_vcnt=289; border elsewhere.
- 2x (REPLICATE_EN), xstart=0, ystart=0 -> addresses 0,0,1,1,...,319,319 on lines 0 and 1; line 2 starts at 320; 640 reads per line; the last read is addr 76799 on line 479.
- xstart=1500, 1x -> each line gives 150 reads (addr base+0..base+149); line_base still steps by 320; nothing leaks into hcnt 0..169 of the next line.
- i_xstart changed 0->200 at i_vcnt=100 -> the current frame keeps xstart 0; the next frame starts reading at i_hcnt=200.
- RAM_LAT=3, 1x, xstart=0, ystart=0 -> pixel latency 5 cycles; o_active high for exactly 320 consecutive cycles per window line.
